// File: rtl/usb_pkg.sv
// Shared USB receive-path types and CRC constants.
package usb_pkg;

    typedef enum logic [1:0] {
        SPECIAL   = 2'b00,
        TOKEN     = 2'b01,
        HANDSHAKE = 2'b10,
        DATA      = 2'b11
    } pkt_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PID  = 2'd1,
        BODY = 2'd2,
        DONE = 2'd3
    } rx_state_t;

    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [10:0] BODY_CNT_MAX   = 11'd2047;

endpackage

// File: rtl/usb_crc_check_if.sv
// Bit-stream input and packet-result output bundle of the USB CRC checker.
interface usb_crc_check_if;

    logic       pkt_begin;
    logic       bit_valid;
    logic       bit_in;
    logic       pkt_end;
    logic       done;
    logic       crc_ok;
    logic       pid_err;
    logic       len_err;
    logic [3:0] pid;
    logic [1:0] pkt_type;

    modport master (
        output pkt_begin, bit_valid, bit_in, pkt_end,
        input  done, crc_ok, pid_err, len_err, pid, pkt_type
    );

    modport slave (
        input  pkt_begin, bit_valid, bit_in, pkt_end,
        output done, crc_ok, pid_err, len_err, pid, pkt_type
    );

endinterface

// File: rtl/usb_crc_lfsr.sv
// Serial MSB-feedback CRC shift register; exposes the value it will hold after this edge.
module usb_crc_lfsr #(
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              en,
    input  logic              bit_in,
    input  logic [DATA_W-1:0] poly,
    output logic [DATA_W-1:0] crc_nxt
);

    logic [DATA_W-1:0] crc;
    logic              fb;

    always_comb begin
        fb      = bit_in ^ crc[DATA_W-1];
        crc_nxt = crc;
        if (init) begin
            crc_nxt = '1;
        end else if (en) begin
            crc_nxt = {crc[DATA_W-2:0], 1'b0} ^ (fb ? poly : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '1;
        end else begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/usb_crc_check.sv
// Receive-side USB packet checker: PID check, CRC5/CRC16 residual check and body length check.
module usb_crc_check
    import usb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    usb_crc_check_if.slave bus
);

    rx_state_t   state, state_nxt;
    logic [7:0]  pid_sr, pid_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic        pid_full;
    logic        crc_init, crc_en;
    logic [4:0]  c5_nxt;
    logic [15:0] c16_nxt;

    logic        res_crc_ok, res_pid_err, res_len_err;
    logic        done_r, crc_ok_r, pid_err_r, len_err_r;
    logic [3:0]  pid_r;
    logic [1:0]  pkt_type_r;

    // Returns {crc_ok, len_err} for a packet whose PID arrived complete.
    function automatic logic [1:0] judge_body(input pkt_type_t ptype,
                                              input logic [10:0] count,
                                              input logic [4:0]  c5,
                                              input logic [15:0] c16);
        logic ok, lerr;
        case (ptype)
            TOKEN: begin
                ok   = (c5 == CRC5_RESIDUAL);
                lerr = (count != 11'd16);
            end
            DATA: begin
                ok   = (c16 == CRC16_RESIDUAL);
                lerr = (count < 11'd16) || (count[2:0] != 3'd0);
            end
            default: begin
                ok   = 1'b1;
                lerr = (count != 11'd0);
            end
        endcase
        return {ok, lerr};
    endfunction

    usb_crc_lfsr #(.DATA_W(5)) u_crc5 (
        .clk     (clk),
        .rst     (rst),
        .init    (crc_init),
        .en      (crc_en),
        .bit_in  (bus.bit_in),
        .poly    (CRC5_POLY),
        .crc_nxt (c5_nxt)
    );

    usb_crc_lfsr #(.DATA_W(16)) u_crc16 (
        .clk     (clk),
        .rst     (rst),
        .init    (crc_init),
        .en      (crc_en),
        .bit_in  (bus.bit_in),
        .poly    (CRC16_POLY),
        .crc_nxt (c16_nxt)
    );

    always_comb begin
        state_nxt = state;
        pid_nxt   = pid_sr;
        cnt_nxt   = cnt;
        pid_full  = 1'b0;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pkt_begin) begin
                    state_nxt = PID;
                    pid_nxt   = 8'd0;
                    cnt_nxt   = 11'd0;
                end
            end
            PID: begin
                if (bus.pkt_begin) begin
                    pid_nxt = 8'd0;
                    cnt_nxt = 11'd0;
                end else begin
                    if (bus.bit_valid) begin
                        pid_nxt[cnt[2:0]] = bus.bit_in;
                        if (cnt[2:0] == 3'd7) begin
                            state_nxt = BODY;
                            cnt_nxt   = 11'd0;
                            crc_init  = 1'b1;
                            pid_full  = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 11'd1;
                        end
                    end
                    // A final bit sampled together with pkt_end is consumed before closing.
                    if (bus.pkt_end) state_nxt = DONE;
                end
            end
            BODY: begin
                if (bus.pkt_begin) begin
                    state_nxt = PID;
                    pid_nxt   = 8'd0;
                    cnt_nxt   = 11'd0;
                end else begin
                    pid_full = 1'b1;
                    if (bus.bit_valid) begin
                        crc_en = 1'b1;
                        if (cnt != BODY_CNT_MAX) cnt_nxt = cnt + 11'd1;
                    end
                    if (bus.pkt_end) state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.pkt_begin) begin
                    state_nxt = PID;
                    pid_nxt   = 8'd0;
                    cnt_nxt   = 11'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        logic [1:0] body_res;
        body_res    = judge_body(pkt_type_t'(pid_nxt[1:0]), cnt_nxt, c5_nxt, c16_nxt);
        res_pid_err = !pid_full || (pid_nxt[7:4] != ~pid_nxt[3:0]);
        res_crc_ok  = pid_full && body_res[1];
        res_len_err = !pid_full || body_res[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pid_sr     <= 8'd0;
            cnt        <= 11'd0;
            done_r     <= 1'b0;
            crc_ok_r   <= 1'b0;
            pid_err_r  <= 1'b0;
            len_err_r  <= 1'b0;
            pid_r      <= 4'd0;
            pkt_type_r <= 2'd0;
        end else begin
            state  <= state_nxt;
            pid_sr <= pid_nxt;
            cnt    <= cnt_nxt;
            done_r <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                crc_ok_r   <= res_crc_ok;
                pid_err_r  <= res_pid_err;
                len_err_r  <= res_len_err;
                pid_r      <= pid_nxt[3:0];
                pkt_type_r <= pid_nxt[1:0];
            end
        end
    end

    assign bus.done     = done_r;
    assign bus.crc_ok   = crc_ok_r;
    assign bus.pid_err  = pid_err_r;
    assign bus.len_err  = len_err_r;
    assign bus.pid      = pid_r;
    assign bus.pkt_type = pkt_type_r;

endmodule
